regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Issue-side controller for the 32x32 two-read/one-write synchronous register file.
- Tracks outstanding writebacks per architectural register and holds back any instruction whose sources are still pending.
- Generates the register-file read enable, so operands are read only on a committed issue.
- Supports a drain sequence used before CSR/fence-style serialisation, plus a pipeline flush.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; at most 2^CNT_W-1 writes in flight per register.
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_v_i  in  1  decode has a valid instruction.
- issue_rs1_i  in  5  source 1 index.
- issue_rs1_used_i  in  1  source 1 is read by this instruction.
- issue_rs2_i  in  5  source 2 index.
- issue_rs2_used_i  in  1  source 2 is read by this instruction.
- issue_rd_i  in  5  destination index.
- issue_rd_we_i  in  1  instruction writes rd.
- issue_ready_o  out  1  issue permitted this cycle (combinational).
- rf_rv_o  out  1  register-file read enable; equals issue fire.
- wb_v_i  in  1  a writeback retires this cycle.
- wb_rd_i  in  5  writeback destination.
- flush_i  in  1  all in-flight instructions are killed.
- drain_req_i  in  1  request to quiesce (level, sampled in RUN).
- drain_done_o  out  1  one-cycle pulse: no writes outstanding.
- busy_o  out  NUM_REGS  bit i = counter i nonzero; bit 0 is always 0.
- stall_cnt_o  out  STALL_W  saturating count of stalled cycles.
- err_o  out  1  sticky: writeback retired to a register with no pending write.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all counters 0; FSM = RUN.
  - busy_o = 0, stall_cnt_o = 0, err_o = 0, drain_done_o = 0.
  - issue_ready_o and rf_rv_o are 0 while reset is asserted.
- Hazard and fire:
  - hazard = (rs1_used && rs1 != 0 && cnt[rs1] != 0) || (the same test for rs2).
  - full = rd_we && rd != 0 && cnt[rd] == max.
  - issue_ready_o = state == RUN && !hazard && !full && !flush_i.
  - fire = issue_v_i && issue_ready_o; rf_rv_o = fire. Read data appears one cycle later from the register file.
- Counter update per register r != 0, next-state:
  - +1 when fire && rd_we && rd == r.
  - −1 when wb_v_i && wb_rd_i == r && cnt[r] != 0.
  - Both on the same register in the same cycle: the count is unchanged.
- No same-cycle bypass: a writeback does not clear a hazard until the following cycle. This is conservative and deliberate.
- wb_v_i to a register whose count is 0, or to x0: the counter does not change and err_o is set. err_o clears only on reset.
- flush_i: the next-state of every counter is 0 and any same-cycle writeback is ignored. The FSM returns to RUN, with no drain_done pulse.
- Stall counter:
  - increments when issue_v_i && !issue_ready_o.
  - saturates at all-ones and never wraps.
- FSM:
  - RUN: drain_req_i → DRAIN. Issue is allowed only in RUN.
  - DRAIN: issue is blocked. When all counters are 0 (the registered value) → DONE.
  - DONE: drain_done_o = 1 for exactly this cycle → RUN. If drain_req_i is still high, the next cycle re-enters DRAIN and pulses again.
  - A drain requested with all counters already 0 produces RUN → DRAIN → DONE, so the pulse comes 2 cycles after the request is sampled.
- Arithmetic: counter increment never overflows, because full blocks issue. Decrement is guarded at 0.

Decomposition:
- Shared package rf_ctrl_pkg holds:
  - typedef reg_idx_t (logic [4:0]).
  - enum sb_state_e {SB_RUN, SB_DRAIN, SB_DONE}.
  - localparam REG_ZERO = 5'd0.
- One sub-module, sb_counter: a single CNT_W up/down counter with inc, dec, clr and nonzero outputs. It is instantiated NUM_REGS−1 times with a generate loop.

Test Plan:
- Reset mid-stream: set cnt[5] = 2, drop reset_n asynchronously → busy_o = 0, err_o = 0, stall_cnt_o = 0 immediately; issue_ready_o = 1 after release.
- RAW stall:
  - Cycle 0: issue rd = 3 with rd_we → busy_o[3] = 1.
  - Cycle 1: issue rs1 = 3 → issue_ready_o = 0 and stall_cnt_o increments.
  - Cycle 2: wb_rd = 3.
  - Cycle 3: ready = 1 and rf_rv_o = 1.
- Same-cycle issue rd = 7 and wb_rd = 7 with cnt[7] = 1 → cnt stays 1; a third issue to rd = 7 at cnt = 3 → ready = 0.
- x0 handling: issue rd = 0 then rs1 = 0 → never stalls and busy_o[0] = 0. wb_rd = 0 → err_o = 1 and stays 1.
- Drain:
  - cnt[9] = 1, assert drain_req → issue blocked.
  - wb_rd = 9 → drain_done_o pulses exactly once, 2 cycles after the writeback.
  - flush_i during DRAIN → state RUN, no pulse.
- Stall saturation: STALL_W = 4, hold a hazard for 20 cycles → stall_cnt_o = 15.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file issue scoreboard.
package rf_ctrl_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_state_e;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: up on issue, down on writeback, clear on flush.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o,
  output logic             nonzero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // inc and dec together cancel; the issue side guarantees inc never overflows
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                  cnt_d = '0;
    else if (inc && !dec)                     cnt_d = cnt_q + 1'b1;
    else if (dec && !inc && (cnt_q != '0))    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side hazard scoreboard for the 2R/1W register file: pending-write
// tracking, RAW hold-off, read-enable generation, drain/flush sequencing.
module regfile_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_v_i,
  input  logic [4:0]          issue_rs1_i,
  input  logic                issue_rs1_used_i,
  input  logic [4:0]          issue_rs2_i,
  input  logic                issue_rs2_used_i,
  input  logic [4:0]          issue_rd_i,
  input  logic                issue_rd_we_i,
  output logic                issue_ready_o,
  output logic                rf_rv_o,
  input  logic                wb_v_i,
  input  logic [4:0]          wb_rd_i,
  input  logic                flush_i,
  input  logic                drain_req_i,
  output logic                drain_done_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [STALL_W-1:0]  stall_cnt_o,
  output logic                err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_state_e          state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt [NUM_REGS];
  logic               nz  [NUM_REGS];
  logic               hazard, full, fire, all_idle;

  // x0 is hard-wired idle
  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    logic hit_rd, hit_wb;
    assign hit_rd = fire && issue_rd_we_i && (issue_rd_i == reg_idx_t'(i));
    assign hit_wb = wb_v_i && !flush_i && (wb_rd_i == reg_idx_t'(i)) && nz[i];
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (hit_rd),
      .dec       (hit_wb),
      .clr       (flush_i),
      .cnt_o     (cnt[i]),
      .nonzero_o (nz[i])
    );
  end

  always_comb begin
    busy_o = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_o[r] = nz[r];
  end

  // Hazards look only at registered counts: a same-cycle writeback does not unblock
  assign hazard = (issue_rs1_used_i && (issue_rs1_i != REG_ZERO) && nz[issue_rs1_i]) ||
                  (issue_rs2_used_i && (issue_rs2_i != REG_ZERO) && nz[issue_rs2_i]);
  assign full   = issue_rd_we_i && (issue_rd_i != REG_ZERO) && (cnt[issue_rd_i] == CNT_MAX);

  assign issue_ready_o = reset_n && (state_q == SB_RUN) && !hazard && !full && !flush_i;
  assign fire          = issue_v_i && issue_ready_o;
  assign rf_rv_o       = fire;
  assign all_idle      = ~|busy_o;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SB_RUN:   if (drain_req_i) state_d = SB_DRAIN;
      SB_DRAIN: if (all_idle)    state_d = SB_DONE;
      SB_DONE:                   state_d = SB_RUN;
      default:                   state_d = SB_RUN;
    endcase
    if (flush_i) state_d = SB_RUN;
  end

  always_comb begin
    stall_d = stall_q;
    if (issue_v_i && !issue_ready_o && (stall_q != '1)) stall_d = stall_q + 1'b1;
    err_d = err_q;
    if (wb_v_i && !flush_i && ((wb_rd_i == REG_ZERO) || !nz[wb_rd_i])) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SB_RUN;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign drain_done_o = (state_q == SB_DONE);
  assign stall_cnt_o  = stall_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a behavioural model queues expected outputs per cycle,
// sampled DUT outputs are queued alongside and compared by each test.
module tb_regfile_scoreboard;

  localparam int SW = 4;

  logic        clk, reset_n;
  logic        issue_v_i, issue_rs1_used_i, issue_rs2_used_i, issue_rd_we_i;
  logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i, wb_rd_i;
  logic        wb_v_i, flush_i, drain_req_i;
  logic        issue_ready_o, rf_rv_o, drain_done_o, err_o;
  logic [31:0] busy_o;
  logic [SW-1:0] stall_cnt_o;

  regfile_scoreboard #(.NUM_REGS(32), .CNT_W(2), .STALL_W(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_v_i(issue_v_i), .issue_rs1_i(issue_rs1_i), .issue_rs1_used_i(issue_rs1_used_i),
    .issue_rs2_i(issue_rs2_i), .issue_rs2_used_i(issue_rs2_used_i),
    .issue_rd_i(issue_rd_i), .issue_rd_we_i(issue_rd_we_i),
    .issue_ready_o(issue_ready_o), .rf_rv_o(rf_rv_o),
    .wb_v_i(wb_v_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i), .drain_req_i(drain_req_i),
    .drain_done_o(drain_done_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          rdy;
    logic          rv;
    logic [31:0]   busy;
    logic          err;
    logic [SW-1:0] stall;
    logic          done;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  obs_t last_o;
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_cnt [32];
  bit m_err;
  int m_stall;
  int m_st;   // 0 run, 1 drain, 2 done

  task automatic do_reset();
    reset_n = 1'b0;
    issue_v_i = 0; issue_rs1_i = 0; issue_rs1_used_i = 0; issue_rs2_i = 0; issue_rs2_used_i = 0;
    issue_rd_i = 0; issue_rd_we_i = 0; wb_v_i = 0; wb_rd_i = 0; flush_i = 0; drain_req_i = 0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0; m_stall = 0; m_st = 0;
    exp_q.delete(); obs_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock of stimulus; model produces the expectation, DUT sample is queued.
  task automatic cyc(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic we, input logic wbv, input logic [4:0] wbrd,
                     input logic fl, input logic dr);
    obs_t e, o;
    logic hz, full, rdy, allz;
    int   nst;
    issue_v_i = v; issue_rs1_i = rs1; issue_rs1_used_i = u1; issue_rs2_i = rs2;
    issue_rs2_used_i = u2; issue_rd_i = rd; issue_rd_we_i = we;
    wb_v_i = wbv; wb_rd_i = wbrd; flush_i = fl; drain_req_i = dr;
    hz   = (u1 && rs1 != 0 && m_cnt[rs1] != 0) || (u2 && rs2 != 0 && m_cnt[rs2] != 0);
    full = we && rd != 0 && m_cnt[rd] == 3;
    rdy  = (m_st == 0) && !hz && !full && !fl;
    allz = 1;
    for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) allz = 0;
    if (fl) nst = 0;
    else case (m_st)
      0:       nst = dr ? 1 : 0;
      1:       nst = allz ? 2 : 1;
      default: nst = 0;
    endcase
    if (v && !rdy && m_stall < 15) m_stall++;
    if (fl) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else begin
      if (wbv) begin
        if (wbrd == 0 || m_cnt[wbrd] == 0) m_err = 1;
        else m_cnt[wbrd]--;
      end
      if (v && rdy && we && rd != 0) m_cnt[rd]++;
    end
    m_st = nst;
    e.rdy = rdy; e.rv = v && rdy; e.busy = '0;
    for (int r = 1; r < 32; r++) e.busy[r] = (m_cnt[r] != 0);
    e.err = m_err; e.stall = SW'(m_stall); e.done = (nst == 2);
    exp_q.push_back(e);
    #2;
    o.rdy = issue_ready_o; o.rv = rf_rv_o;
    @(posedge clk); #1;
    o.busy = busy_o; o.err = err_o; o.stall = stall_cnt_o; o.done = drain_done_o;
    obs_q.push_back(o);
    last_o = o;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    obs_t e, o;
    do_reset();
    n_cmp++; if (busy_o !== '0)     begin n_bad++; $display("FAIL rst_busy: got %h want 0", busy_o); end
    n_cmp++; if (err_o !== 1'b0)    begin n_bad++; $display("FAIL rst_err: got %b want 0", err_o); end
    n_cmp++; if (stall_cnt_o !== 0) begin n_bad++; $display("FAIL rst_stall: got %0d want 0", stall_cnt_o); end
    n_cmp++; if (drain_done_o !== 0) begin n_bad++; $display("FAIL rst_done: got %b want 0", drain_done_o); end
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sb_reset: got %h want %h", o, e); end
    end
    // async reset between edges, with a valid issue presented
    issue_v_i = 1; issue_rs1_used_i = 0; issue_rd_we_i = 0; wb_v_i = 0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (busy_o !== '0)      begin n_bad++; $display("FAIL async_busy: got %h want 0", busy_o); end
    n_cmp++; if (err_o !== 1'b0)     begin n_bad++; $display("FAIL async_err: got %b want 0", err_o); end
    n_cmp++; if (stall_cnt_o !== 0)  begin n_bad++; $display("FAIL async_stall: got %0d want 0", stall_cnt_o); end
    n_cmp++; if (issue_ready_o !== 0) begin n_bad++; $display("FAIL async_ready: got %b want 0", issue_ready_o); end
    n_cmp++; if (rf_rv_o !== 0)      begin n_bad++; $display("FAIL async_rv: got %b want 0", rf_rv_o); end
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0; m_stall = 0; m_st = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b want 1", last_o.rdy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sb_reset2: got %h want %h", o, e); end
    end
  endtask

  task automatic test_raw();
    obs_t e, o;
    do_reset();
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    n_cmp++; if (last_o.busy[3] !== 1'b1) begin n_bad++; $display("FAIL raw_busy3: got %b want 1", last_o.busy[3]); end
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b0) begin n_bad++; $display("FAIL raw_hold: got %b want 0", last_o.rdy); end
    n_cmp++; if (last_o.stall !== 1)  begin n_bad++; $display("FAIL raw_stall: got %0d want 1", last_o.stall); end
    cyc(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b0) begin n_bad++; $display("FAIL raw_nobypass: got %b want 0", last_o.rdy); end
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (last_o.rv !== 1'b1)  begin n_bad++; $display("FAIL raw_fire: got %b want 1", last_o.rv); end
    cyc(1, 0, 0, 3, 1, 3, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b0) begin n_bad++; $display("FAIL raw_rs2_hold: got %b want 0", last_o.rdy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sb_raw: got %h want %h", o, e); end
    end
  endtask

  task automatic test_same_cycle();
    obs_t e, o;
    do_reset();
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b1) begin n_bad++; $display("FAIL same_cnt2: got %b want 1", last_o.rdy); end
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b1) begin n_bad++; $display("FAIL same_cnt3: got %b want 1", last_o.rdy); end
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b0) begin n_bad++; $display("FAIL same_full: got %b want 0", last_o.rdy); end
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    n_cmp++; if (last_o.busy[7] !== 1'b0) begin n_bad++; $display("FAIL same_drained: got %b want 0", last_o.busy[7]); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sb_same: got %h want %h", o, e); end
    end
  endtask

  task automatic test_x0();
    obs_t e, o;
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    n_cmp++; if (last_o.busy[0] !== 1'b0) begin n_bad++; $display("FAIL x0_busy: got %b want 0", last_o.busy[0]); end
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %b want 1", last_o.rdy); end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (last_o.err !== 1'b1) begin n_bad++; $display("FAIL x0_err: got %b want 1", last_o.err); end
    idle(3);
    n_cmp++; if (last_o.err !== 1'b1) begin n_bad++; $display("FAIL x0_sticky: got %b want 1", last_o.err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sb_x0: got %h want %h", o, e); end
    end
  endtask

  task automatic test_drain();
    obs_t e, o;
    logic [4:0] pat;
    int pulses;
    do_reset();
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1);
    n_cmp++; if (last_o.rdy !== 1'b0) begin n_bad++; $display("FAIL drain_block: got %b want 0", last_o.rdy); end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    pat = {4'b0, last_o.done};
    for (int k = 1; k < 5; k++) begin
      idle(1);
      pat[k] = last_o.done;
    end
    n_cmp++; if (pat !== 5'b00010) begin n_bad++; $display("FAIL drain_pulse: got %b want 00010", pat); end
    // flush while draining: back to RUN, no pulse
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      pulses += last_o.done;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL flush_nopulse: got %0d want 0", pulses); end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (last_o.rdy !== 1'b1) begin n_bad++; $display("FAIL flush_run: got %b want 1", last_o.rdy); end
    n_cmp++; if (last_o.err !== 1'b0) begin n_bad++; $display("FAIL flush_wb_ignored: got %b want 0", last_o.err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sb_drain: got %h want %h", o, e); end
    end
  endtask

  task automatic test_stall_sat();
    obs_t e, o;
    do_reset();
    cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (last_o.stall !== 4'd15) begin n_bad++; $display("FAIL stall_sat: got %0d want 15", last_o.stall); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sb_stall: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    logic wbv;
    logic [4:0] wbrd;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      wbv = 0; wbrd = 0;
      if ($urandom_range(0, 1) == 1) begin
        for (int r = 1; r < 8; r++)
          if (m_cnt[r] != 0 && !wbv && $urandom_range(0, 2) != 0) begin wbv = 1; wbrd = 5'(r); end
      end
      cyc(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), wbv, wbrd, 1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 9) == 0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sb_b2b: got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_same_cycle();
    test_x0();
    test_drain();
    test_stall_sat();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
